spi_eeprom_slave: RTL
=====================

// Module: spi_eeprom_slave
// PURPOSE
//  Synthesizable SPI mode-0 responder emulating a 128x8 serial EEPROM (25AA010A-class command set).
//  It is the slave end of the SPI link that the Wishbone SPI master drives, and serves as an on-chip target
//  and loop-back check for that master. SCK/CS_N/MOSI are oversampled in the system clock domain.
// PARAMETERS
//  ADDR_W        7    byte address width; depth = 2**ADDR_W
//  PAGE_BYTES    16   page-write buffer size; power of 2, <= 2**ADDR_W
//  WRITE_CYCLES  500  CLK_I cycles WIP stays 1 after a write/WRSR commit; minimum = PAGE_BYTES+1
//  SYNC_STAGES   2    flip-flop synchronizer depth on SCK, CS_N, MOSI
// PORTS
//  CLK_I     in   1  system clock; all logic on its rising edge
//  RST_I     in   1  synchronous, active-high reset
//  SCK       in   1  SPI clock, asynchronous to CLK_I, idle low (mode 0)
//  CS_N      in   1  chip select, active low
//  MOSI      in   1  serial data in, MSB first
//  MISO      out  1  serial data out, MSB first
//  MISO_OE   out  1  1 = MISO driven (synchronized CS_N low)
//  WIP       out  1  write-in-progress, mirror of status bit 0
// BEHAVIOUR
//  Reset: MISO=0, MISO_OE=0, WIP=0, status={4'b0,BP=2'b00,WEL=0,WIP=0}, FSM=IDLE. Memory array is not cleared.
//  Sampling:
//   - SCK/CS_N/MOSI pass through SYNC_STAGES flops; rise/fall detected on synchronized SCK.
//   - MOSI sampled on SCK rise. MISO updated on SCK fall; first read bit is driven on the fall after the last address bit.
//   - Input-to-MISO latency is SYNC_STAGES+1 CLK_I cycles.
//   - SCK high and low each must last >= SYNC_STAGES+2 CLK_I cycles.
//  Framing:
//   - CS_N falling starts a frame; bit counter=0; FSM=CMD.
//   - CS_N rising ends the frame from any state; FSM=IDLE and MISO_OE=0 on the same cycle.
//  FSM states: IDLE, CMD, ADDR, RDATA, WDATA, WRSR, RDSR, IGNORE.
//   - CMD (8 bits):
//     - 0x03 READ -> ADDR. 0x02 WRITE -> ADDR if WEL=1, else IGNORE.
//     - 0x06 WREN: sets WEL at frame end. 0x04 WRDI: clears WEL at frame end.
//     - 0x05 RDSR -> RDSR. 0x01 WRSR -> WRSR if WEL=1, else IGNORE.
//     - Any other opcode -> IGNORE.
//     - While WIP=1, every opcode except RDSR -> IGNORE.
//   - ADDR (8 bits): address = low ADDR_W bits; upper bits ignored. Then READ -> RDATA, WRITE -> WDATA.
//   - RDATA: shifts mem[addr]; address increments after each byte and wraps 2**ADDR_W-1 -> 0. Unlimited length.
//   - RDSR: repeatedly shifts the status byte; live WIP is reflected at each byte start.
//   - WDATA:
//     - Each complete byte goes to page buffer slot (addr mod PAGE_BYTES); column then increments and wraps
//       within the page (upper address bits fixed).
//     - Bytes beyond PAGE_BYTES overwrite earlier slots; a per-slot valid mask records which slots were written.
//   - WRSR: first complete byte latches BP<=bit[3:2] at frame end; further bytes ignored.
//   - IGNORE: MISO=0 until CS_N rises.
//  Commit (CS_N rising):
//   - WRITE commits only if bit counter is on a byte boundary and >= 1 data byte was received.
//     Otherwise discard everything and keep WEL.
//   - WRSR has the same byte-boundary rule.
//   - On commit: WIP=1 for WRITE_CYCLES cycles. Valid buffer slots are copied to the array one per cycle
//     during that time. WEL=0 when WIP falls.
//  Write protect:
//   - BP=01 protects the top quarter, BP=10 the top half, BP=11 the whole array.
//   - A WRITE whose page lies in the protected region does not commit: no WIP, WEL cleared.
//  Reset mid-operation: frame aborted, an in-progress copy stops (partially written page allowed), WIP=0.
//  Simultaneous events:
//   - CS_N rise on the same cycle as an SCK edge: CS_N wins and the edge is ignored.
//   - RDSR frames during WIP are fully served.
// TESTING
//  1. RST_I pulse -> MISO=0, MISO_OE=0, WIP=0; RDSR returns 0x00.
//  2. WREN; WRITE addr 0x10 data A5,5A,C3; wait WIP=0; READ 0x10 x3 -> A5,5A,C3; RDSR -> 0x00 (WEL cleared).
//  3. WREN; WRITE addr 0x1E data 11,22,33 -> 0x1E=11, 0x1F=22, 0x10=33 (page wrap); 0x20 unchanged.
//  4. READ at 0x7F for 2 bytes -> mem[0x7F], mem[0x00]; WRITE without WREN -> no WIP, data unchanged.
//  5. WREN; WRITE 0x40 then CS_N high after 12 data bits -> no commit, WEL=1. RDSR during a valid commit -> bit0=1.
//  6. WREN; WRSR 0x0C; WREN; WRITE 0x00 -> protected: no change, WIP stays 0; RST_I mid-READ -> MISO_OE=0 next cycle.

Source files
------------

// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 slave emulating a small serial EEPROM (READ/WRITE/WREN/WRDI/RDSR/WRSR).
// SCK, CS_N and MOSI are oversampled in the CLK_I domain; writes commit through a page buffer.
module spi_eeprom_slave #(
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned PAGE_BYTES   = 16,
    parameter int unsigned WRITE_CYCLES = 500,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic SCK,
    input  logic CS_N,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_OE,
    output logic WIP
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned COL_W = $clog2(PAGE_BYTES);
    localparam int unsigned IDX_W = COL_W + 1;
    localparam int unsigned CNT_W = $clog2(WRITE_CYCLES);
    localparam logic [ADDR_W-1:0] PROT_Q = ADDR_W'(DEPTH - DEPTH/4);
    localparam logic [ADDR_W-1:0] PROT_H = ADDR_W'(DEPTH/2);
    localparam logic [7:0] OP_WRSR = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_WRSR, S_RDSR, S_IGNORE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
    logic r_sck_prev, r_cs_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_tx;
    logic r_miso, r_miso_oe;
    logic [1:0] r_bp, r_bp_pend;
    logic r_wel, r_wip, r_copy_en;
    logic [CNT_W-1:0] r_wip_cnt;
    logic [IDX_W-1:0] r_copy_idx;
    logic r_pend_wren, r_pend_wrdi, r_sr_got, r_is_write;
    logic [ADDR_W-1:0] r_addr;
    logic [PAGE_BYTES-1:0] r_valid;
    logic [7:0] r_buf [PAGE_BYTES];
    logic [7:0] r_mem [DEPTH];

    logic w_sck, w_cs, w_mosi;
    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
    logic w_bit_ev, w_byte_done, w_wr_byte, w_protected, w_copy_we;
    logic [7:0] w_byte, w_status;
    logic [COL_W-1:0] w_col, w_col_nxt, w_copy_col;
    logic [ADDR_W-1:0] w_page_start;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_rise  = w_cs & ~r_cs_prev;
    assign w_cs_fall  = ~w_cs & r_cs_prev;

    // CS_N edges take priority over any coincident SCK edge
    assign w_bit_ev    = w_sck_rise && !w_cs_rise && !w_cs_fall && (r_state != S_IDLE);
    assign w_byte_done = w_bit_ev && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift, w_mosi};
    assign w_wr_byte   = w_byte_done && (r_state == S_WDATA);
    assign w_status    = {4'b0000, r_bp, r_wel, r_wip};

    assign w_col        = r_addr[COL_W-1:0];
    assign w_col_nxt    = w_col + COL_W'(1);
    assign w_page_start = {r_addr[ADDR_W-1:COL_W], COL_W'(0)};
    assign w_copy_col   = r_copy_idx[COL_W-1:0];
    assign w_copy_we    = r_wip && r_copy_en && (r_copy_idx != IDX_W'(PAGE_BYTES))
                          && r_valid[w_copy_col];

    always_comb begin
        case (r_bp)
            2'b01:   w_protected = (w_page_start >= PROT_Q);
            2'b10:   w_protected = (w_page_start >= PROT_H);
            2'b11:   w_protected = 1'b1;
            default: w_protected = 1'b0;
        endcase
    end

    // Input synchronizers (no reset: they only carry pin state)
    always_ff @(posedge CLK_I) begin
        r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
        r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_N};
        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
        end else if (w_cs_fall) begin
            w_state_nxt = S_CMD;
        end else if (w_byte_done) begin
            case (r_state)
                S_CMD: begin
                    if (r_wip && (w_byte != OP_RDSR)) w_state_nxt = S_IGNORE;
                    else begin
                        case (w_byte)
                            OP_READ:  w_state_nxt = S_ADDR;
                            OP_WRITE: w_state_nxt = r_wel ? S_ADDR : S_IGNORE;
                            OP_RDSR:  w_state_nxt = S_RDSR;
                            OP_WRSR:  w_state_nxt = r_wel ? S_WRSR : S_IGNORE;
                            default:  w_state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR:  w_state_nxt = r_is_write ? S_WDATA : S_RDATA;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            // Edge history follows the pins so a held-low CS_N does not restart a frame
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_tx        <= 8'd0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_bp        <= 2'b00;
            r_bp_pend   <= 2'b00;
            r_wel       <= 1'b0;
            r_wip       <= 1'b0;
            r_copy_en   <= 1'b0;
            r_wip_cnt   <= CNT_W'(0);
            r_copy_idx  <= IDX_W'(0);
            r_pend_wren <= 1'b0;
            r_pend_wrdi <= 1'b0;
            r_sr_got    <= 1'b0;
            r_is_write  <= 1'b0;
            r_addr      <= ADDR_W'(0);
            r_valid     <= PAGE_BYTES'(0);
        end else begin
            r_sck_prev <= w_sck;
            r_cs_prev  <= w_cs;
            if (r_wip) begin
                if (r_wip_cnt == CNT_W'(0)) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end else begin
                    r_wip_cnt <= r_wip_cnt - CNT_W'(1);
                end
                if (r_copy_idx != IDX_W'(PAGE_BYTES)) r_copy_idx <= r_copy_idx + IDX_W'(1);
            end
            if (w_cs_rise) begin
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
                if (r_pend_wren) r_wel <= 1'b1;
                if (r_pend_wrdi) r_wel <= 1'b0;
                if (r_state == S_WDATA && r_bit_cnt == 3'd0 && |r_valid) begin
                    if (w_protected) begin
                        r_wel <= 1'b0;
                    end else begin
                        r_wip      <= 1'b1;
                        r_wip_cnt  <= CNT_W'(WRITE_CYCLES - 1);
                        r_copy_idx <= IDX_W'(0);
                        r_copy_en  <= 1'b1;
                    end
                end
                if (r_state == S_WRSR && r_bit_cnt == 3'd0 && r_sr_got) begin
                    r_bp       <= r_bp_pend;
                    r_wip      <= 1'b1;
                    r_wip_cnt  <= CNT_W'(WRITE_CYCLES - 1);
                    r_copy_idx <= IDX_W'(0);
                    r_copy_en  <= 1'b0;
                end
            end else if (w_cs_fall) begin
                r_miso      <= 1'b0;
                r_miso_oe   <= 1'b1;
                r_bit_cnt   <= 3'd0;
                r_pend_wren <= 1'b0;
                r_pend_wrdi <= 1'b0;
                r_sr_got    <= 1'b0;
            end else if (w_bit_ev) begin
                r_shift   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (w_byte_done) begin
                    case (r_state)
                        S_CMD: begin
                            r_is_write <= (w_byte == OP_WRITE);
                            if (!r_wip && w_byte == OP_WREN) r_pend_wren <= 1'b1;
                            if (!r_wip && w_byte == OP_WRDI) r_pend_wrdi <= 1'b1;
                        end
                        S_ADDR: begin
                            r_addr <= w_byte[ADDR_W-1:0];
                            if (r_is_write) r_valid <= PAGE_BYTES'(0);
                        end
                        S_WDATA: begin
                            r_valid[w_col] <= 1'b1;
                            r_addr <= {r_addr[ADDR_W-1:COL_W], w_col_nxt};
                        end
                        S_WRSR: begin
                            if (!r_sr_got) begin
                                r_sr_got  <= 1'b1;
                                r_bp_pend <= w_byte[3:2];
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (w_sck_fall && r_state != S_IDLE) begin
                // Byte boundary loads a fresh byte; otherwise keep shifting MSB first
                if (r_state == S_RDATA && r_bit_cnt == 3'd0) begin
                    r_miso <= r_mem[r_addr][7];
                    r_tx   <= {r_mem[r_addr][6:0], 1'b0};
                    r_addr <= r_addr + ADDR_W'(1);
                end else if (r_state == S_RDSR && r_bit_cnt == 3'd0) begin
                    r_miso <= w_status[7];
                    r_tx   <= {w_status[6:0], 1'b0};
                end else if (r_state == S_RDATA || r_state == S_RDSR) begin
                    r_miso <= r_tx[7];
                    r_tx   <= {r_tx[6:0], 1'b0};
                end else begin
                    r_miso <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I && w_wr_byte) r_buf[w_col] <= w_byte;
    end

    // Page commit: one buffered byte per cycle while WIP is high
    always_ff @(posedge CLK_I) begin
        if (!RST_I && w_copy_we) r_mem[{r_addr[ADDR_W-1:COL_W], w_copy_col}] <= r_buf[w_copy_col];
    end

    assign MISO    = r_miso;
    assign MISO_OE = r_miso_oe;
    assign WIP     = r_wip;

endmodule
